// File: rtl/alu_op_decoder.sv
// MIPS-style instruction decoder feeding the integer ALU. Registered outputs behind a
// two-entry skid buffer with a flopped in_ready and a saturating illegal-instruction counter.
module alu_op_decoder #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [5:0]           out_funct,
  output logic [4:0]           out_shamt,
  output logic [4:0]           out_rs_idx,
  output logic [4:0]           out_rt_idx,
  output logic [4:0]           out_rd_idx,
  output logic [31:0]          out_imm,
  output logic                 out_use_imm,
  output logic                 out_reg_write,
  output logic                 out_illegal,
  output logic [CNT_WIDTH-1:0] illegal_count
);

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnXor = 6'b100110;
  localparam logic [5:0] FnNor = 6'b100111;
  localparam logic [5:0] FnSll = 6'b000000;
  localparam logic [5:0] FnSrl = 6'b000010;
  localparam logic [5:0] FnSra = 6'b000011;

  typedef struct packed {
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        reg_write;
    logic        illegal;
  } dec_t;

  dec_t dec;
  dec_t main_q, main_d, skid_q, skid_d;
  logic main_valid_q, main_valid_d;
  logic skid_valid_q, skid_valid_d;
  logic ready_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [5:0] op;
  logic       accept;
  logic       legal;

  assign op     = in_instr[31:26];
  assign accept = in_valid & ready_q & ~flush;

  always_comb begin
    dec   = '0;
    legal = 1'b1;
    unique case (op)
      6'b000000: begin
        dec.funct     = in_instr[5:0];
        dec.shamt     = in_instr[10:6];
        dec.rs        = in_instr[25:21];
        dec.rt        = in_instr[20:16];
        dec.rd        = in_instr[15:11];
        dec.reg_write = (in_instr[15:11] != 5'd0);
        unique case (in_instr[5:0])
          FnAdd, FnSub, FnAnd, FnOr, FnXor, FnNor, FnSll, FnSrl, FnSra: legal = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        dec.rs        = in_instr[25:21];
        dec.rd        = in_instr[20:16];
        dec.use_imm   = 1'b1;
        dec.reg_write = (in_instr[20:16] != 5'd0);
        dec.imm       = {16'h0000, in_instr[15:0]};
        unique case (op)
          6'b001000: begin
            dec.funct = FnAdd;
            dec.imm   = {{16{in_instr[15]}}, in_instr[15:0]};
          end
          6'b001100: dec.funct = FnAnd;
          6'b001101: dec.funct = FnOr;
          6'b001110: dec.funct = FnXor;
          default: begin
            dec.funct = FnOr;
            dec.rs    = 5'd0;
            dec.imm   = {in_instr[15:0], 16'h0000};
          end
        endcase
      end
      default: legal = 1'b0;
    endcase
    // Illegal entries carry a neutral, non-writing add so downstream needs no special case
    if (!legal) begin
      dec         = '0;
      dec.funct   = FnAdd;
      dec.illegal = 1'b1;
    end
  end

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_valid_q && !out_ready) begin
      // Main held: a new entry can only land in the skid (in_ready implies skid empty)
      if (accept) begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end else if (skid_valid_q) begin
      main_d       = skid_q;
      main_valid_d = 1'b1;
      if (accept) begin
        skid_d = dec;
      end else begin
        skid_valid_d = 1'b0;
      end
    end else begin
      main_valid_d = accept;
      if (accept) main_d = dec;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept && dec.illegal && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      cnt_q        <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ~skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready      = ready_q;
  assign out_valid     = main_valid_q;
  assign out_funct     = main_q.funct;
  assign out_shamt     = main_q.shamt;
  assign out_rs_idx    = main_q.rs;
  assign out_rt_idx    = main_q.rt;
  assign out_rd_idx    = main_q.rd;
  assign out_imm       = main_q.imm;
  assign out_use_imm   = main_q.use_imm;
  assign out_reg_write = main_q.reg_write;
  assign out_illegal   = main_q.illegal;
  assign illegal_count = cnt_q;

endmodule
